// File: rtl/key_match_sequencer.sv
// key_match_sequencer: steers a 16-bit candidate key, one nibble per handshake,
// through an external 4-bit comparator, accumulates the chunk results and
// issues a one-cycle unlock/fail verdict with consecutive-failure tracking.
// Optional feature macro: CITADEL_LOCKOUT_EN builds the timed lockout state.
module key_match_sequencer #(
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_nibble,
  output logic        key_ready,
  input  logic        abort,
  input  logic [15:0] ref_key,
  output logic [3:0]  cmp_a,
  output logic [3:0]  cmp_b,
  input  logic        cmp_eq,
  output logic        unlock,
  output logic        fail,
  output logic        locked,
  output logic        busy,
  output logic [2:0]  fail_count
);

  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned FC_W  = 3;
  localparam logic [FC_W-1:0] FC_SAT = FC_W'(7);

  localparam bit P_CFG_OK = (MAX_FAILS >= 1) && (MAX_FAILS <= 7) &&
                            (LOCKOUT_CYCLES >= 1) && (LOCKOUT_CYCLES <= 65535);

`ifdef CITADEL_LOCKOUT_EN
  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_VERDICT = 2'd1,
    S_LOCKOUT = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_VERDICT = 2'd1
  } state_t;
`endif

  state_t            r_state;
  state_t            w_state_nx;
  logic [IDX_W-1:0]  r_idx;
  logic              r_acc;
  logic              r_unlock;
  logic              r_fail;
  logic [FC_W-1:0]   r_fail_count;
`ifdef CITADEL_LOCKOUT_EN
  logic [CNT_W-1:0]  r_lock_cnt;
`endif

  logic              w_hs;
  logic              w_last;
  logic              w_final;
  logic [FC_W-1:0]   w_fc_inc;

  assign w_hs    = key_valid && key_ready;
  assign w_last  = w_hs && (r_idx == IDX_W'(3));
  assign w_final = r_acc & cmp_eq;

`ifdef CITADEL_LOCKOUT_EN
  // count never exceeds MAX_FAILS here: reaching it forces lockout, which clears it
  assign w_fc_inc = r_fail_count + FC_W'(1);
`else
  assign w_fc_inc = (r_fail_count == FC_SAT) ? FC_SAT : (r_fail_count + FC_W'(1));
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // next-state decode
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_COLLECT: begin
        if (w_last) begin
          w_state_nx = S_VERDICT;
        end
      end
      S_VERDICT: begin
`ifdef CITADEL_LOCKOUT_EN
        // r_fail/r_fail_count already reflect this verdict
        if (r_fail && (r_fail_count == FC_W'(MAX_FAILS))) begin
          w_state_nx = S_LOCKOUT;
        end else begin
          w_state_nx = S_COLLECT;
        end
`else
        w_state_nx = S_COLLECT;
`endif
      end
`ifdef CITADEL_LOCKOUT_EN
      S_LOCKOUT: begin
        if (r_lock_cnt <= CNT_W'(1)) begin
          w_state_nx = S_COLLECT;
        end
      end
`endif
      default: begin
        w_state_nx = S_COLLECT;
      end
    endcase
  end

  // output decode: handshake, comparator steering and status flags
  always_comb begin
    key_ready = (r_state == S_COLLECT) && !abort;
    cmp_a     = key_nibble;
    case (r_idx)
      2'd0:    cmp_b = ref_key[15:12];
      2'd1:    cmp_b = ref_key[11:8];
      2'd2:    cmp_b = ref_key[7:4];
      default: cmp_b = ref_key[3:0];
    endcase
    busy = (r_idx != IDX_W'(0)) || (r_state == S_VERDICT);
`ifdef CITADEL_LOCKOUT_EN
    locked = (r_state == S_LOCKOUT);
`else
    locked = 1'b0;
`endif
  end

  // chunk index, match accumulator, verdict pulses and failure count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= '0;
      r_acc        <= 1'b1;
      r_unlock     <= 1'b0;
      r_fail       <= 1'b0;
      r_fail_count <= '0;
      assert (P_CFG_OK) else $error("key_match_sequencer: parameter out of range");
    end else begin
      r_unlock <= 1'b0;
      r_fail   <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          if (abort) begin
            r_idx <= '0;
            r_acc <= 1'b1;
          end else if (w_hs) begin
            if (r_idx == IDX_W'(3)) begin
              // final chunk: latch verdict and rearm for the next entry
              r_idx    <= '0;
              r_acc    <= 1'b1;
              r_unlock <= w_final;
              r_fail   <= !w_final;
              r_fail_count <= w_final ? '0 : w_fc_inc;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
              r_acc <= w_final;
            end
          end
        end
`ifdef CITADEL_LOCKOUT_EN
        S_LOCKOUT: begin
          if (r_lock_cnt <= CNT_W'(1)) begin
            r_fail_count <= '0;
            r_acc        <= 1'b1;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

`ifdef CITADEL_LOCKOUT_EN
  // lockout timer: loaded on entry, counts down once per locked cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_cnt <= '0;
    end else if ((r_state == S_VERDICT) && (w_state_nx == S_LOCKOUT)) begin
      r_lock_cnt <= CNT_W'(LOCKOUT_CYCLES);
    end else if ((r_state == S_LOCKOUT) && (r_lock_cnt != '0)) begin
      r_lock_cnt <= r_lock_cnt - CNT_W'(1);
    end
  end
`endif

  assign unlock     = r_unlock;
  assign fail       = r_fail;
  assign fail_count = r_fail_count;

endmodule
